network_tx_arbiter: RTL
=======================

# network_tx_arbiter

Packet-granular round-robin arbiter that shares the single 512-bit network TX stream between N_SRC requesters, such as the RDMA, TCP and ARP/ICMP engines. It sits in front of the Ethernet frame padding stage on the network clock domain. It never interleaves beats of different packets. Packets longer than MAX_BEATS are truncated, so one faulty source cannot stall the CMAC path.

## Interface
Parameters:
- N_SRC, 4, number of requesting streams (2..8)
- DATA_BITS, 512, stream data width (AXI_NET_BITS); tkeep width is DATA_BITS/8
- MAX_BEATS, 150, maximum beats per packet (150 × 64 B = 9600 B jumbo frame)

Ports:
- aclk  in  1  network clock (rclk)
- areset  in  1  asynchronous, active-high reset
- s_axis_tvalid  in  N_SRC  per-source valid
- s_axis_tready  out  N_SRC  per-source ready
- s_axis_tdata  in  N_SRC*DATA_BITS  source i occupies bits [i*DATA_BITS +: DATA_BITS]
- s_axis_tkeep  in  N_SRC*DATA_BITS/8  per-source keep, same packing rule
- s_axis_tlast  in  N_SRC  per-source last
- src_en  in  N_SRC  arbitration enable mask; sampled only in IDLE
- m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/DATA_BITS/DATA_BITS/8/1  merged TX stream
- m_axis_tsrc  out  $clog2(N_SRC)  index of the source owning the current output beat
- trunc_cnt  out  32  count of truncated packets
- pkt_cnt  out  N_SRC*32  per-source forwarded packet counters (see Configuration)

## Operation
- State machine:
  - IDLE: pick the first source i with s_axis_tvalid[i] & src_en[i], searching from last_grant+1 upward, modulo N_SRC.
    - Register grant = i and move to FWD.
    - If no source qualifies, stay in IDLE.
  - FWD: s_axis_tready[grant] = out_free; all other s_axis_tready bits are 0. out_free = !m_axis_tvalid | m_axis_tready.
    - Each accepted beat loads the output register and increments beat_cnt (8 bits).
    - Accepted tlast: last_grant <= grant, beat_cnt <= 0, go to IDLE.
    - Accepted beat without tlast while beat_cnt == MAX_BEATS-1: forward that beat with tlast forced to 1, increment trunc_cnt, go to DROP.
  - DROP: s_axis_tready[grant] = 1 and nothing is forwarded. On accepted tlast: last_grant <= grant, beat_cnt <= 0, go to IDLE.
- Deasserting src_en[i] mid-packet has no effect until that packet's tlast.
- Source tvalid deasserting mid-packet: the grant is held and the arbiter waits; there is no timeout.
- m_axis_tsrc is registered together with the data beat.
- Counters wrap modulo 2^32.
- trunc_cnt is always present.

## Timing
- Reset values:
  - state = IDLE, last_grant = N_SRC-1, so source 0 wins first.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = 0, m_axis_tsrc = 0.
  - s_axis_tready = 0, trunc_cnt = 0, pkt_cnt = 0.
- Latency: a beat accepted on the source side at edge t is valid on m_axis after edge t, i.e. one register stage.
- Throughput inside a packet is 1 beat/cycle while m_axis_tready = 1.
- Arbitration costs exactly one bubble cycle per packet: IDLE lasts one cycle, during which no s_axis_tready is asserted.
- Output holding: the output register holds tdata, tkeep, tlast and tsrc stable while m_axis_tvalid & !m_axis_tready, as AXI-Stream requires.
- s_axis_tready[grant] is combinational from m_axis_tready. No combinational path exists from s_axis_tvalid to m_axis.
- An output beat still pending at the transition to IDLE or DROP stays valid until accepted.
- Arbitration in IDLE does not depend on out_free.
- Asserting areset mid-packet clears the state immediately. The partial packet is lost downstream; the frame padding stage and packet FIFO are reset in the same domain.
- Boundary cases:
  - A single-beat packet (tlast on the first beat) gives FWD → IDLE after one beat.
  - A packet of exactly MAX_BEATS beats ending in tlast is not truncated.

## Configuration
- NET_TX_ARB_STATS_EN defined:
  - pkt_cnt[i*32 +: 32] increments when source i's tlast is accepted in FWD or DROP.
  - Truncated packets count once.
- NET_TX_ARB_STATS_EN undefined: pkt_cnt is tied to 0 and its counter logic is removed. The port remains.

## Test plan
- Round robin: all four sources continuously offer 2-beat packets with m_axis_tready = 1. Required: m_axis_tsrc order 0,1,2,3,0,…; each packet is 2 contiguous beats followed by a 1-cycle gap.
- Masking and fairness:
  - Clear src_en[1] while source 1 is mid-packet. Required: its current packet completes, then source 1 is skipped; order becomes 2,3,0,2,….
  - Reassert src_en[1]. Required: source 1 resumes in order.
- Backpressure: random m_axis_tready at 50% with source 2 sending a 5-beat packet of tdata pattern 0xA5… Required: beats arrive unchanged and in order; outputs stay stable during stalls; other sources are never granted mid-packet.
- Truncation with MAX_BEATS = 4: source 0 sends 7 beats. Required: 4 beats out with tlast on beat 4; beats 5–7 are consumed and not forwarded; trunc_cnt = 1; the next grant goes to source 1.
- Reset: assert areset during beat 3 of a packet. Required: m_axis_tvalid = 0 and s_axis_tready = 0 asynchronously; after release the first grant is source 0 and counters read 0.
- Stats, with NET_TX_ARB_STATS_EN: send 3 packets from source 3 and 1 truncated packet from source 0. Required: pkt_cnt[3] = 3 and pkt_cnt[0] = 1. Without the macro, pkt_cnt = 0.

Source files
------------

// File: rtl/network_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : network_tx_arbiter_if
// Brief    : Source-side and merged-side AXI-Stream bundle of the TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface network_tx_arbiter_if #(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 512
) ();
    localparam int c_SRC_W = $clog2(N_SRC);

    logic [N_SRC-1:0]             s_axis_tvalid;
    logic [N_SRC-1:0]             s_axis_tready;
    logic [N_SRC*DATA_BITS-1:0]   s_axis_tdata;
    logic [N_SRC*DATA_BITS/8-1:0] s_axis_tkeep;
    logic [N_SRC-1:0]             s_axis_tlast;

    logic                         m_axis_tvalid;
    logic                         m_axis_tready;
    logic [DATA_BITS-1:0]         m_axis_tdata;
    logic [DATA_BITS/8-1:0]       m_axis_tkeep;
    logic                         m_axis_tlast;
    logic [c_SRC_W-1:0]           m_axis_tsrc;

    // Environment side: drives the sources and the merged-stream ready.
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
               m_axis_tsrc
    );

    // Arbiter side.
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
               m_axis_tsrc
    );
endinterface
`default_nettype wire

// File: rtl/network_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : network_tx_arbiter
// Brief    : Packet-granular round-robin arbiter onto one TX stream, with
//            MAX_BEATS truncation. NET_TX_ARB_STATS_EN enables pkt_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module network_tx_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 512,
    parameter int MAX_BEATS = 150
) (
    input  wire                   aclk,
    input  wire                   areset,
    network_tx_arbiter_if.slave   axis,
    input  wire  [N_SRC-1:0]      src_en,
    output logic [31:0]           trunc_cnt,
    output logic [N_SRC*32-1:0]   pkt_cnt
);
    localparam int         c_SRC_W     = $clog2(N_SRC);
    localparam int         c_KEEP_BITS = DATA_BITS / 8;
    localparam logic [7:0] c_LAST_BEAT = 8'(MAX_BEATS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FWD  = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    logic [1:0]             r_state;
    logic [c_SRC_W-1:0]     r_grant;
    logic [c_SRC_W-1:0]     r_last_grant;
    logic [7:0]             r_beat_cnt;
    logic [31:0]            r_trunc_cnt;

    logic                   r_m_valid;
    logic [DATA_BITS-1:0]   r_m_data;
    logic [c_KEEP_BITS-1:0] r_m_keep;
    logic                   r_m_last;
    logic [c_SRC_W-1:0]     r_m_src;

    logic [DATA_BITS-1:0]   w_src_data [N_SRC];
    logic [c_KEEP_BITS-1:0] w_src_keep [N_SRC];
    logic [N_SRC-1:0]       w_s_ready;
    logic                   w_out_free;
    logic                   w_grant_valid;
    logic                   w_grant_last;
    logic                   w_accept;
    logic                   w_fwd_beat;
    logic                   w_pkt_done;
    logic                   w_trunc;
    logic                   w_req;
    logic [c_SRC_W-1:0]     w_pick;
    logic [c_SRC_W-1:0]     w_pos;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
        assign w_src_data[gi] = axis.s_axis_tdata[gi*DATA_BITS +: DATA_BITS];
        assign w_src_keep[gi] = axis.s_axis_tkeep[gi*c_KEEP_BITS +: c_KEEP_BITS];
    end

    assign w_out_free    = !r_m_valid | axis.m_axis_tready;
    assign w_grant_valid = axis.s_axis_tvalid[r_grant];
    assign w_grant_last  = axis.s_axis_tlast[r_grant];

    always_comb begin
        w_s_ready = '0;
        if (r_state == c_FWD) begin
            w_s_ready[r_grant] = w_out_free;
        end else if (r_state == c_DROP) begin
            w_s_ready[r_grant] = 1'b1;
        end
    end

    assign w_accept   = w_grant_valid & w_s_ready[r_grant];
    assign w_fwd_beat = (r_state == c_FWD) & w_accept;
    assign w_pkt_done = w_accept & w_grant_last;
    assign w_trunc    = w_fwd_beat & !w_grant_last & (r_beat_cnt == c_LAST_BEAT);

    // Walk downward so the closest source after last_grant is the one left standing.
    always_comb begin
        w_req  = 1'b0;
        w_pick = '0;
        w_pos  = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_pos = c_SRC_W'((int'(r_last_grant) + k) % N_SRC);
            if (axis.s_axis_tvalid[w_pos] && src_en[w_pos]) begin
                w_req  = 1'b1;
                w_pick = w_pos;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= c_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_SRC_W'(N_SRC - 1);
            r_beat_cnt   <= '0;
            r_trunc_cnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_grant <= w_pick;
                        r_state <= c_FWD;
                    end
                end
                c_FWD: begin
                    if (w_fwd_beat) begin
                        if (w_grant_last) begin
                            r_last_grant <= r_grant;
                            r_beat_cnt   <= '0;
                            r_state      <= c_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                            if (w_trunc) begin
                                r_trunc_cnt <= r_trunc_cnt + 32'd1;
                                r_state     <= c_DROP;
                            end
                        end
                    end
                end
                c_DROP: begin
                    if (w_pkt_done) begin
                        r_last_grant <= r_grant;
                        r_beat_cnt   <= '0;
                        r_state      <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Output stage: loads only on an accepted FWD beat, otherwise holds until drained.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_src   <= '0;
        end else if (w_fwd_beat) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_src_data[r_grant];
            r_m_keep  <= w_src_keep[r_grant];
            r_m_last  <= w_grant_last | w_trunc;
            r_m_src   <= r_grant;
        end else if (axis.m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign axis.s_axis_tready = w_s_ready;
    assign axis.m_axis_tvalid = r_m_valid;
    assign axis.m_axis_tdata  = r_m_data;
    assign axis.m_axis_tkeep  = r_m_keep;
    assign axis.m_axis_tlast  = r_m_last;
    assign axis.m_axis_tsrc   = r_m_src;
    assign trunc_cnt          = r_trunc_cnt;

`ifdef NET_TX_ARB_STATS_EN
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_stats
        logic [31:0] r_cnt;
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_cnt <= '0;
            end else if (w_pkt_done && (r_grant == c_SRC_W'(gi))) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign pkt_cnt[gi*32 +: 32] = r_cnt;
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule
`default_nettype wire
